psum_buf: RTL and testbench

PSUM_BUF -- requirements
Module: psum_buf

---
 rtl/psum_buf.sv | 107 ++++++++++
 tb/tb_psum_buf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_buf.sv
// Partial-sum buffer: a streaming psum write port with a re-basable write pointer,
// a registered psum read port, and an independent host-loaded bias array.
module psum_buf #(
  parameter int AW = 10,
  parameter int DW = 22,
  parameter int DN = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_start,
  input  logic [AW-1:0]        wr_base,
  input  logic                 wr_valid,
  input  logic [DW*DN-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW*DN-1:0]     rd_data,
  input  logic                 bias_we,
  input  logic [AW-1:0]        bias_waddr,
  input  logic [DW*DN-1:0]     bias_wdata,
  input  logic [AW-1:0]        bias_raddr,
  output logic [DW*DN-1:0]     bias_rdata,
  output logic [AW:0]          wr_count,
  output logic                 wr_err
);

  localparam int EW    = DW * DN;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  logic [EW-1:0] r_psum [DEPTH];
  logic [EW-1:0] r_bias [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_wr_count;
  logic          r_armed;
  logic          r_wr_err;
  logic [EW-1:0] r_rd_data;
  logic [EW-1:0] r_bias_rdata;

  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic          w_rd_hit;
  logic          w_bias_hit;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
    return (c == CNT_MAX) ? c : c + (AW+1)'(1);
  endfunction

  // A wr_start in the same cycle as wr_valid both arms the pass and steers
  // that first write to wr_base, so the stream never loses its head entry.
  assign w_wr_en    = wr_valid && (r_armed || wr_start);
  assign w_wr_addr  = wr_start ? wr_base : r_wr_ptr;
  assign w_rd_hit   = w_wr_en && (w_wr_addr == rd_addr);
  assign w_bias_hit = bias_we && (bias_waddr == bias_raddr);

  // Write-pass control: pointer, saturating count, armed and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_wr_count <= '0;
      r_armed    <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      if (wr_start)
        r_armed <= 1'b1;

      if (w_wr_en)
        r_wr_ptr <= w_wr_addr + AW'(1);
      else if (wr_start)
        r_wr_ptr <= wr_base;

      if (wr_start)
        r_wr_count <= w_wr_en ? (AW+1)'(1) : '0;
      else if (w_wr_en)
        r_wr_count <= sat_inc(r_wr_count);

      if (wr_valid && !r_armed && !wr_start)
        r_wr_err <= 1'b1;
    end
  end

  // Storage arrays carry no reset; contents are undefined until written
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_psum[w_wr_addr] <= wr_data;
    if (bias_we)
      r_bias[bias_waddr] <= bias_wdata;
  end

  // Registered read ports, write-first on an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data    <= '0;
      r_bias_rdata <= '0;
    end else begin
      if (rd_en)
        r_rd_data <= w_rd_hit ? wr_data : r_psum[rd_addr];
      r_bias_rdata <= w_bias_hit ? bias_wdata : r_bias[bias_raddr];
    end
  end

  assign rd_data    = r_rd_data;
  assign bias_rdata = r_bias_rdata;
  assign wr_count   = r_wr_count;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_psum_buf.sv
// Directed bench for psum_buf: stimulus pushes expected read data into queues,
// a negedge monitor pops and compares whenever a read response is due.
module tb_psum_buf;
  localparam int AW = 10;
  localparam int DW = 22;
  localparam int DN = 6;
  localparam int EW = DW * DN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_start = 1'b0;
  logic [AW-1:0] wr_base = '0;
  logic          wr_valid = 1'b0;
  logic [EW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [EW-1:0] rd_data;
  logic          bias_we = 1'b0;
  logic [AW-1:0] bias_waddr = '0;
  logic [EW-1:0] bias_wdata = '0;
  logic [AW-1:0] bias_raddr = '0;
  logic [EW-1:0] bias_rdata;
  logic [AW:0]   wr_count;
  logic          wr_err;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_rd_q[$];
  logic [EW-1:0] exp_bias_q[$];
  logic bias_chk = 1'b0;
  logic rd_due = 1'b0;
  logic bias_due = 1'b0;

  always #5 clk = ~clk;

  psum_buf #(.AW(AW), .DW(DW), .DN(DN)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_start(wr_start), .wr_base(wr_base), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
    .bias_raddr(bias_raddr), .bias_rdata(bias_rdata),
    .wr_count(wr_count), .wr_err(wr_err)
  );

  // Distinct per-lane pattern for entry number s
  function automatic logic [EW-1:0] mk(input int s);
    logic [EW-1:0] r;
    for (int i = 0; i < DN; i++) r[i*DW +: DW] = DW'(s * 37 + i * 5 + 1);
    return r;
  endfunction

  always @(posedge clk) begin
    rd_due   <= rd_en && rst_n;
    bias_due <= bias_chk && rst_n;
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rd_due) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_data unexpected response got=%h", rd_data);
      end else begin
        e = exp_rd_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data got=%h exp=%h", rd_data, e);
        end
      end
    end
    if (bias_due) begin
      checks++;
      if (exp_bias_q.size() == 0) begin
        failures++;
        $display("FAIL bias_rdata unexpected response got=%h", bias_rdata);
      end else begin
        e = exp_bias_q.pop_front();
        if (bias_rdata !== e) begin
          failures++;
          $display("FAIL bias_rdata got=%h exp=%h", bias_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic clr();
    wr_start = 1'b0; wr_base = '0; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; bias_we = 1'b0; bias_waddr = '0;
    bias_wdata = '0; bias_chk = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    tick();
    clr();
  endtask

  task automatic wr(input logic st, input int base, input logic v, input logic [EW-1:0] d);
    wr_start = st; wr_base = AW'(base); wr_valid = v; wr_data = d;
  endtask

  task automatic rd(input int a, input logic [EW-1:0] e);
    rd_en = 1'b1; rd_addr = AW'(a); exp_rd_q.push_back(e);
  endtask

  task automatic brd(input int a, input logic [EW-1:0] e);
    bias_raddr = AW'(a); bias_chk = 1'b1; exp_bias_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    tick(); tick();
    chk("reset_rd_data", rd_data, '0);
    chk("reset_bias_rdata", bias_rdata, '0);
    chk("reset_wr_count", wr_count, '0);
    chk("reset_wr_err", wr_err, '0);
    rst_n = 1'b1;

    // Unarmed write right after reset flags an error and counts nothing
    wr(0, 0, 1, mk(99)); cyc();
    chk("unarmed_wr_err", wr_err, 1);
    chk("unarmed_wr_count", wr_count, '0);
    rst_n = 1'b0; #1;
    chk("reset_clears_wr_err", wr_err, '0);
    tick(); rst_n = 1'b1;

    // Basic pass at base 5
    wr(1, 5, 0, '0); cyc();
    for (int i = 0; i < 4; i++) begin wr(0, 0, 1, mk(1 + i)); cyc(); end
    chk("basic_wr_count", wr_count, 4);
    for (int i = 0; i < 4; i++) begin rd(5 + i, mk(1 + i)); cyc(); end
    cyc(); cyc();
    chk("rd_hold", rd_data, mk(4));

    // Saturation: 1025 writes from base 0, first one alongside wr_start
    wr(1, 0, 1, mk(1000)); cyc();
    for (int k = 1; k <= 1024; k++) begin
      wr(0, 0, 1, mk(1000 + k)); cyc();
      if (k == 1023) chk("sat_count_1024", wr_count, 1024);
    end
    chk("sat_count_hold", wr_count, 1024);
    rd(0, mk(2024)); cyc();
    rd(1, mk(1001)); cyc();
    rd(5, mk(1005)); cyc();

    // Pointer wrap from 1022
    wr(1, 1022, 0, '0); cyc();
    for (int i = 0; i < 4; i++) begin wr(0, 0, 1, mk(11 + i)); cyc(); end
    chk("wrap_wr_count", wr_count, 4);
    chk("wrap_wr_err", wr_err, '0);
    rd(1022, mk(11)); cyc();
    rd(1023, mk(12)); cyc();
    rd(0, mk(13)); cyc();
    rd(1, mk(14)); cyc();

    // Same-cycle start and write
    wr(1, 10, 1, mk(21)); cyc();
    wr(0, 0, 1, mk(22)); cyc();
    chk("samecycle_wr_count", wr_count, 2);
    rd(10, mk(21)); cyc();
    rd(11, mk(22)); cyc();

    // Bypass at pointer 20, with an unrelated read running alongside the write
    wr(1, 19, 1, mk(31)); rd(1022, mk(11)); cyc();
    wr(0, 0, 1, mk(32)); rd(20, mk(32)); cyc();
    rd(20, mk(32)); cyc();
    rd(19, mk(31)); cyc();

    // Bias port
    bias_we = 1'b1; bias_waddr = 4; bias_wdata = mk(42); cyc();
    bias_we = 1'b1; bias_waddr = 3; bias_wdata = mk(41); brd(3, mk(41)); cyc();
    brd(4, mk(42)); cyc();
    brd(3, mk(41)); cyc();
    cyc();

    // Reset mid-pass
    wr(1, 100, 1, mk(51)); cyc();
    wr(0, 0, 1, mk(52)); cyc();
    wr(0, 0, 1, mk(53));
    rst_n = 1'b0; #1;
    chk("midreset_rd_data", rd_data, '0);
    chk("midreset_bias_rdata", bias_rdata, '0);
    chk("midreset_wr_count", wr_count, '0);
    chk("midreset_wr_err", wr_err, '0);
    tick(); clr();
    rst_n = 1'b1;
    wr(0, 0, 1, mk(61)); cyc();
    chk("postreset_wr_err", wr_err, 1);
    chk("postreset_wr_count", wr_count, '0);
    rd(0, mk(13)); cyc();
    rd(101, mk(52)); cyc();
    wr(1, 200, 1, mk(62)); cyc();
    chk("rearm_wr_count", wr_count, 1);
    rd(200, mk(62)); cyc();
    cyc(); cyc();
    chk("err_sticky", wr_err, 1);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), '0);
    chk("bias_queue_drained", 32'(exp_bias_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
